lane_slot_scheduler: RTL and testbench
======================================

LANE_SLOT_SCHEDULER -- requirements
Module: lane_slot_scheduler

Interface
REQ-001 SHALL have parameter FU_LATENCY, default 4, meaning pipelined complex-op latency, legal range 2..DIV_LATENCY-1.
REQ-002 SHALL have parameter DIV_LATENCY, default 8, meaning unpipelined divider latency, legal range FU_LATENCY+1..32.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port simpleReq_i, input, 1, simple (latency-1) candidate present this cycle.
REQ-006 SHALL have port complexReq_i, input, 1, pipelined complex candidate present this cycle.
REQ-007 SHALL have port divReq_i, input, 1, divide candidate present this cycle.
REQ-008 SHALL have ports simpleDest_i, complexDest_i and divDest_i, each input, phys_reg, destination tag of the matching candidate.
REQ-009 SHALL have port flush_i, input, 1, squash of all in-flight lane operations.
REQ-010 SHALL have port grant_o, output, 3, one-hot {div, complex, simple} grant, combinational.
REQ-011 SHALL have port rsrTag_o, output, phys_reg, wakeup tag broadcast, registered.
REQ-012 SHALL have ports blockSimple_o and blockComplex_o, each output, 1, the corresponding wakeup slot is already reserved, combinational from state only.
REQ-013 SHALL have port divBusy_o, output, 1, divider FSM not IDLE.

Function
REQ-014 SHALL grant at most one request per cycle, at fixed priority div > complex > simple.
REQ-015 SHALL grant a request with latency L in cycle t only if no earlier grant already broadcasts in cycle t+L; a blocked request falls through to the next priority.
REQ-016 SHALL drive rsrTag_o.valid=1 with the granted tag in exactly cycle t+L for a grant in cycle t: L=1 simple, FU_LATENCY complex, DIV_LATENCY div.
REQ-017 SHALL drive rsrTag_o.valid=0 in every cycle with no reserved slot; reg_id is then don't-care but held at 0.
REQ-018 SHALL hold state as a DIV_LATENCY-deep slot vector with tag store, shifting one position per cycle; a grant writes position L-1 after the shift.
REQ-019 SHALL assert blockSimple_o when the next-cycle slot is reserved, and blockComplex_o when the slot FU_LATENCY cycles ahead is reserved.
REQ-020 SHALL implement the divider FSM: IDLE to BUSY on div grant; stay in BUSY while the count is nonzero; BUSY to IDLE in the cycle the div tag broadcasts.
REQ-021 SHALL load the FSM counter with DIV_LATENCY-1 on grant and decrement it once per cycle.
REQ-022 SHALL not grant divReq_i unless the FSM is IDLE.
REQ-023 SHALL clear all slots and tags on flush_i, force the FSM to IDLE, force grant_o=0 in the flush cycle, and drive rsrTag_o.valid=0 in the following cycle.
REQ-024 SHALL give flush_i precedence over any same-cycle request or FSM transition.
REQ-025 SHALL keep grant_o combinational in the request cycle, with no request-to-grant register.

Reset
REQ-026 SHALL, while reset is high, asynchronously clear all slots, tags and counter, set the FSM to IDLE, and drive rsrTag_o=0 (valid 0, reg_id 0), blockSimple_o=0, blockComplex_o=0 and divBusy_o=0.
REQ-027 SHALL, while reset is high, drive grant_o=0 regardless of requests.
REQ-028 SHALL accept requests from the first rising edge after reset deasserts.

Structure
REQ-029 SHALL take phys_reg and SIZE_PHYSICAL_LOG from the shared core package.
REQ-030 SHALL add the divider FSM state enum (IDLE, BUSY) to the shared package.
REQ-031 SHALL keep the divider FSM and counter in one sub-module, lane_div_sequencer; the slot vector and arbitration stay in lane_slot_scheduler.

Verification (FU_LATENCY=4, DIV_LATENCY=8)
REQ-032 SHALL cover: simpleReq_i with tag 5 in cycle 10 -> grant_o=001, rsrTag_o={1,5} in cycle 11 only.
REQ-033 SHALL cover: complex tag 7 in cycle 10, then simple tag 9 in cycle 13 -> blockSimple_o=1 in cycle 13, simple not granted, tag 7 broadcast in cycle 14.
REQ-034 SHALL cover: all three requests in cycle 20 with divider IDLE -> grant_o=100; divBusy_o=1 in cycles 21..27; div tag broadcast in cycle 28; a divReq_i in cycle 24 is not granted.
REQ-035 SHALL cover: complex granted in cycle 30, flush_i in cycle 32 -> rsrTag_o.valid=0 in cycles 33..35, divBusy_o=0.
REQ-036 SHALL cover: reset asserted mid-divide, asynchronously to clk -> all outputs 0 immediately; a simple request after release is granted on the first edge.
REQ-037 SHALL cover: randomized requests checked against a reference model -> never two broadcasts in one cycle, every grant broadcasts exactly at t+L.

Source files
------------

// File: rtl/lane_slot_scheduler_pkg.sv
// rtl/lane_slot_scheduler_pkg.sv - shared core types for the lane slot scheduler
package lane_slot_scheduler_pkg;

  localparam int SIZE_PHYSICAL_LOG = 6;

  typedef struct packed {
    logic                         valid;
    logic [SIZE_PHYSICAL_LOG-1:0] reg_id;
  } phys_reg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } div_state_e;

endpackage

// File: rtl/lane_div_sequencer.sv
// rtl/lane_div_sequencer.sv - unpipelined divider occupancy FSM and countdown
module lane_div_sequencer
  import lane_slot_scheduler_pkg::*;
#(
  parameter int DIV_LATENCY = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic start_i,
  input  logic flush_i,
  output logic busy_o
);

  localparam int CNT_W = $clog2(DIV_LATENCY);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;

  // State and counter registers, cleared asynchronously by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Next state: flush wins; BUSY ends on the edge that makes the div tag broadcast.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    if (flush_i) begin
      state_d = IDLE;
      count_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_d = BUSY;
            count_d = CNT_LOAD;
          end
        end
        BUSY: begin
          count_d = count_q - 1'b1;
          if (count_q == CNT_LAST) state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
          count_d = '0;
        end
      endcase
    end
  end

  assign busy_o = (state_q == BUSY);

endmodule

// File: rtl/lane_slot_scheduler.sv
// rtl/lane_slot_scheduler.sv - writeback-slot arbitration for simple/complex/div lane ops
module lane_slot_scheduler
  import lane_slot_scheduler_pkg::*;
#(
  parameter int FU_LATENCY  = 4,
  parameter int DIV_LATENCY = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       simpleReq_i,
  input  logic       complexReq_i,
  input  logic       divReq_i,
  input  phys_reg    simpleDest_i,
  input  phys_reg    complexDest_i,
  input  phys_reg    divDest_i,
  input  logic       flush_i,
  output logic [2:0] grant_o,
  output phys_reg    rsrTag_o,
  output logic       blockSimple_o,
  output logic       blockComplex_o,
  output logic       divBusy_o
);

  // slot_q[i] holds the tag that broadcasts i cycles from now; slot_q[0] is this cycle.
  phys_reg [DIV_LATENCY-1:0] slot_q, slot_d;
  phys_reg                   write_tag;
  logic                      div_busy;

  lane_div_sequencer #(
    .DIV_LATENCY(DIV_LATENCY)
  ) u_div_seq (
    .clk    (clk),
    .reset  (reset),
    .start_i(grant_o[2]),
    .flush_i(flush_i),
    .busy_o (div_busy)
  );

  assign rsrTag_o       = slot_q[0];
  assign blockSimple_o  = slot_q[1].valid;
  assign blockComplex_o = slot_q[FU_LATENCY].valid;
  assign divBusy_o      = div_busy;

  // Fixed-priority arbitration; a blocked candidate falls through to the next one.
  always_comb begin
    grant_o = 3'b000;
    if (!reset && !flush_i) begin
      if (divReq_i && !div_busy)                grant_o = 3'b100;
      else if (complexReq_i && !blockComplex_o) grant_o = 3'b010;
      else if (simpleReq_i && !blockSimple_o)   grant_o = 3'b001;
    end
  end

  // Shift the slot vector by one and drop the granted tag at its broadcast position.
  always_comb begin
    if (grant_o[2])      write_tag = divDest_i;
    else if (grant_o[1]) write_tag = complexDest_i;
    else                 write_tag = simpleDest_i;
    write_tag.valid = 1'b1;

    slot_d = '0;
    for (int i = 0; i < DIV_LATENCY - 1; i++) slot_d[i] = slot_q[i+1];
    if (grant_o[0]) slot_d[0]               = write_tag;
    if (grant_o[1]) slot_d[FU_LATENCY-1]    = write_tag;
    if (grant_o[2]) slot_d[DIV_LATENCY-1]   = write_tag;
    if (flush_i)    slot_d                  = '0;
  end

  // Slot vector register, cleared asynchronously by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) slot_q <= '0;
    else       slot_q <= slot_d;
  end

endmodule

// File: tb/tb_lane_slot_scheduler.sv
// tb/tb_lane_slot_scheduler.sv - self-checking bench for lane_slot_scheduler
module tb_lane_slot_scheduler;
  import lane_slot_scheduler_pkg::*;

  logic       clk;
  logic       reset;
  logic       simple_req, complex_req, div_req, flush;
  phys_reg    simple_dest, complex_dest, div_dest;
  logic [2:0] grant;
  phys_reg    rsr_tag;
  logic       block_simple, block_complex, div_busy;

  int checks   = 0;
  int failures = 0;

  lane_slot_scheduler #(.FU_LATENCY(4), .DIV_LATENCY(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .simpleReq_i   (simple_req),
    .complexReq_i  (complex_req),
    .divReq_i      (div_req),
    .simpleDest_i  (simple_dest),
    .complexDest_i (complex_dest),
    .divDest_i     (div_dest),
    .flush_i       (flush),
    .grant_o       (grant),
    .rsrTag_o      (rsr_tag),
    .blockSimple_o (block_simple),
    .blockComplex_o(block_complex),
    .divBusy_o     (div_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       s, c, d;
    logic [5:0] st, ct, dt;
    logic       fl;
    logic [2:0] g;
    logic       rv;
    logic [5:0] rid;
    logic       bs, bc, bz;
  } vec_t;

  vec_t vecs[29];

  function automatic vec_t mk(input logic s, input logic c, input logic d,
                              input int st, input int ct, input int dt, input logic fl,
                              input logic [2:0] g, input logic rv, input int rid,
                              input logic bs, input logic bc, input logic bz);
    vec_t v;
    v.s = s; v.c = c; v.d = d;
    v.st = 6'(st); v.ct = 6'(ct); v.dt = 6'(dt);
    v.fl = fl; v.g = g; v.rv = rv; v.rid = 6'(rid);
    v.bs = bs; v.bc = bc; v.bz = bz;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic c, input logic d,
                       input logic [5:0] st, input logic [5:0] ct, input logic [5:0] dt,
                       input logic fl);
    simple_req = s; complex_req = c; div_req = d; flush = fl;
    simple_dest.valid  = 1'b1; simple_dest.reg_id  = st;
    complex_dest.valid = 1'b1; complex_dest.reg_id = ct;
    div_dest.valid     = 1'b1; div_dest.reg_id     = dt;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  logic       cal_v[0:1023];
  logic [5:0] cal_t[0:1023];

  initial begin
    logic [2:0] eg;
    logic       rs, rc, rd, rf;
    logic [5:0] ts, tc, td;
    int         div_free;

    vecs[0]  = mk(0,0,0, 0, 0, 0,0, 3'b000, 0, 0, 0,0,0);
    vecs[1]  = mk(1,0,0, 5, 0, 0,0, 3'b001, 0, 0, 0,0,0);
    vecs[2]  = mk(0,0,0, 0, 0, 0,0, 3'b000, 1, 5, 0,0,0);
    vecs[3]  = mk(0,0,0, 0, 0, 0,0, 3'b000, 0, 0, 0,0,0);
    vecs[4]  = mk(0,1,0, 0, 7, 0,0, 3'b010, 0, 0, 0,0,0);
    vecs[5]  = mk(0,0,0, 0, 0, 0,0, 3'b000, 0, 0, 0,0,0);
    vecs[6]  = mk(0,0,0, 0, 0, 0,0, 3'b000, 0, 0, 0,0,0);
    vecs[7]  = mk(1,0,0, 9, 0, 0,0, 3'b000, 0, 0, 1,0,0);
    vecs[8]  = mk(0,0,0, 0, 0, 0,0, 3'b000, 1, 7, 0,0,0);
    vecs[9]  = mk(0,0,0, 0, 0, 0,0, 3'b000, 0, 0, 0,0,0);
    vecs[10] = mk(1,1,1, 1, 2, 3,0, 3'b100, 0, 0, 0,0,0);
    vecs[11] = mk(0,1,0, 0, 4, 0,0, 3'b010, 0, 0, 0,0,1);
    vecs[12] = mk(1,0,0, 6, 0, 0,0, 3'b001, 0, 0, 0,0,1);
    vecs[13] = mk(0,0,0, 0, 0, 0,0, 3'b000, 1, 6, 0,0,1);
    vecs[14] = mk(0,0,1, 0, 0,11,0, 3'b000, 0, 0, 1,1,1);
    vecs[15] = mk(0,0,0, 0, 0, 0,0, 3'b000, 1, 4, 0,0,1);
    vecs[16] = mk(1,0,1,21, 0,20,0, 3'b001, 0, 0, 0,0,1);
    vecs[17] = mk(1,1,0,12,13, 0,0, 3'b010, 1,21, 1,0,1);
    vecs[18] = mk(0,0,1, 0, 0,14,0, 3'b100, 1, 3, 0,0,0);
    vecs[19] = mk(0,0,0, 0, 0, 0,0, 3'b000, 0, 0, 0,0,1);
    vecs[20] = mk(0,0,0, 0, 0, 0,0, 3'b000, 0, 0, 1,0,1);
    vecs[21] = mk(0,0,0, 0, 0, 0,0, 3'b000, 1,13, 0,0,1);
    vecs[22] = mk(1,1,0,23,22, 0,0, 3'b001, 0, 0, 0,1,1);
    vecs[23] = mk(0,1,0, 0,24, 0,0, 3'b010, 1,23, 0,0,1);
    vecs[24] = mk(0,0,0, 0, 0, 0,0, 3'b000, 0, 0, 0,0,1);
    vecs[25] = mk(1,0,1,25, 0,26,1, 3'b000, 0, 0, 1,0,1);
    vecs[26] = mk(0,0,0, 0, 0, 0,0, 3'b000, 0, 0, 0,0,0);
    vecs[27] = mk(0,0,0, 0, 0, 0,0, 3'b000, 0, 0, 0,0,0);
    vecs[28] = mk(0,0,0, 0, 0, 0,0, 3'b000, 0, 0, 0,0,0);

    // Reset state, with requests present to show grant is held off.
    reset = 1'b1;
    drive(1, 1, 1, 6'd1, 6'd2, 6'd3, 0);
    #3;
    chk("reset grant", 32'(grant), 32'd0);
    chk("reset rsr", 32'(rsr_tag), 32'd0);
    chk("reset block_simple", 32'(block_simple), 32'd0);
    chk("reset block_complex", 32'(block_complex), 32'd0);
    chk("reset div_busy", 32'(div_busy), 32'd0);
    drive(0, 0, 0, 6'd0, 6'd0, 6'd0, 0);
    @(posedge clk);
    #4 reset = 1'b0;
    tick;

    // Directed table, one row per cycle.
    for (int i = 0; i < 29; i++) begin
      drive(vecs[i].s, vecs[i].c, vecs[i].d, vecs[i].st, vecs[i].ct, vecs[i].dt, vecs[i].fl);
      #2;
      chk($sformatf("vec%0d grant", i), 32'(grant), 32'(vecs[i].g));
      chk($sformatf("vec%0d rsr", i), 32'(rsr_tag), 32'({vecs[i].rv, vecs[i].rid}));
      chk($sformatf("vec%0d block_simple", i), 32'(block_simple), 32'(vecs[i].bs));
      chk($sformatf("vec%0d block_complex", i), 32'(block_complex), 32'(vecs[i].bc));
      chk($sformatf("vec%0d div_busy", i), 32'(div_busy), 32'(vecs[i].bz));
      tick;
    end

    // Asynchronous reset in the middle of a divide.
    drive(0, 0, 1, 6'd0, 6'd0, 6'd40, 0);
    #2;
    chk("middiv grant", 32'(grant), 32'b100);
    tick;
    drive(0, 0, 0, 6'd0, 6'd0, 6'd0, 0);
    tick;
    tick;
    chk("middiv busy", 32'(div_busy), 32'd1);
    drive(1, 0, 1, 6'd30, 6'd0, 6'd41, 0);
    #2 reset = 1'b1;
    #1;
    chk("async reset grant", 32'(grant), 32'd0);
    chk("async reset rsr", 32'(rsr_tag), 32'd0);
    chk("async reset busy", 32'(div_busy), 32'd0);
    chk("async reset blocks", 32'({block_simple, block_complex}), 32'd0);
    @(posedge clk);
    #4 reset = 1'b0;
    drive(1, 0, 0, 6'd30, 6'd0, 6'd0, 0);
    #1;
    chk("post reset grant", 32'(grant), 32'b001);
    tick;
    drive(0, 0, 0, 6'd0, 6'd0, 6'd0, 0);
    chk("post reset rsr", 32'(rsr_tag), 32'({1'b1, 6'd30}));
    chk("post reset busy", 32'(div_busy), 32'd0);
    tick;

    // Randomized traffic against a cycle-indexed broadcast calendar.
    reset = 1'b1;
    #2 reset = 1'b0;
    tick;
    for (int t = 0; t < 1024; t++) begin
      cal_v[t] = 1'b0;
      cal_t[t] = 6'd0;
    end
    div_free = 0;
    for (int t = 0; t < 300; t++) begin
      rs = 1'($urandom_range(0, 1));
      rc = 1'($urandom_range(0, 1));
      rd = ($urandom_range(0, 3) == 0);
      rf = ($urandom_range(0, 19) == 0);
      ts = 6'($urandom_range(1, 63));
      tc = 6'($urandom_range(1, 63));
      td = 6'($urandom_range(1, 63));
      drive(rs, rc, rd, ts, tc, td, rf);
      eg = 3'b000;
      if (!rf) begin
        if (rd && t >= div_free)     eg = 3'b100;
        else if (rc && !cal_v[t+4])  eg = 3'b010;
        else if (rs && !cal_v[t+1])  eg = 3'b001;
      end
      #2;
      chk($sformatf("rand%0d grant", t), 32'(grant), 32'(eg));
      chk($sformatf("rand%0d rsr", t), 32'(rsr_tag),
          32'({cal_v[t], cal_v[t] ? cal_t[t] : 6'd0}));
      chk($sformatf("rand%0d div_busy", t), 32'(div_busy), 32'(t < div_free));
      if (rf) begin
        for (int k = 1; k <= 8; k++) cal_v[t+k] = 1'b0;
        div_free = t + 1;
      end else if (eg == 3'b100) begin
        cal_v[t+8] = 1'b1; cal_t[t+8] = td; div_free = t + 8;
      end else if (eg == 3'b010) begin
        cal_v[t+4] = 1'b1; cal_t[t+4] = tc;
      end else if (eg == 3'b001) begin
        cal_v[t+1] = 1'b1; cal_t[t+1] = ts;
      end
      tick;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
